// File: rtl/clock_divide_n.sv
// clock_divide_n: programmable integer clock divider.
// Produces a registered divided clock (high ceil(N/2), low floor(N/2) cycles)
// plus single-cycle rise/fall strobes. The divisor is loaded through a
// valid/ready handshake and only takes effect at a period boundary.
// Optional feature macro: CLKDIV_PERIOD_CNT_EN adds a saturating period
// counter output (period_cnt), cleared whenever the divider returns to idle.
module clock_divide_n #(
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             enable,
  input  logic             div_valid,
  input  logic [DIV_W-1:0] div_value,
  output logic             div_ready,
  output logic             div_err,
  output logic             clk_out,
  output logic             rise_tick,
  output logic             fall_tick,
  output logic             busy
`ifdef CLKDIV_PERIOD_CNT_EN
  ,
  output logic [15:0]      period_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [DIV_W-1:0] RESET_DIV = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] ONE       = DIV_W'(1);
  localparam logic [DIV_W-1:0] TWO       = DIV_W'(2);

  state_t           state;
  state_t           state_next;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] cur_div;
  logic [DIV_W-1:0] pend_div;
  logic             pend_full;

  logic [DIV_W-1:0] high_time;
  logic [DIV_W-1:0] last_cnt;
  logic             step;
  logic             wrap;
  logic             accept;
  logic             reject;
  logic             apply;

  // Period arithmetic and handshake decode shared by the FSM and datapath.
  always_comb begin
    high_time = cur_div - (cur_div >> 1);
    last_cnt  = cur_div - ONE;
    // A step runs every edge while busy, and also on the edge leaving IDLE.
    step      = (state != IDLE) || enable;
    wrap      = step && (cnt == last_cnt);
    accept    = div_valid && div_ready && (div_value >= TWO);
    reject    = div_valid && div_ready && (div_value < TWO);
    apply     = pend_full && ((state == IDLE) || wrap);
  end

  // State register.
  always_ff @(posedge clk_in) begin
    // NOTE: sequential state always uses non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic: stop only at a period boundary with enable low.
  always_comb begin
    // NOTE: default assigned first so no path leaves state_next unassigned,
    // which would otherwise infer a latch.
    state_next = state;
    case (state)
      IDLE:    if (enable) state_next = RUN;
      RUN:     if (!enable) state_next = wrap ? IDLE : DRAIN;
      DRAIN: begin
        if (enable)    state_next = RUN;
        else if (wrap) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Period counter, registered clock/strobes and divisor handshake.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      cnt       <= '0;
      cur_div   <= RESET_DIV;
      pend_div  <= '0;
      pend_full <= 1'b0;
      div_ready <= 1'b1;
      div_err   <= 1'b0;
      clk_out   <= 1'b0;
      rise_tick <= 1'b0;
      fall_tick <= 1'b0;
    end else begin
      if (step) begin
        clk_out   <= (cnt < high_time);
        rise_tick <= (cnt == '0);
        fall_tick <= (cnt == high_time);
        cnt       <= wrap ? '0 : cnt + ONE;
      end else begin
        clk_out   <= 1'b0;
        rise_tick <= 1'b0;
        fall_tick <= 1'b0;
        cnt       <= '0;
      end

      div_err <= reject;

      // Pending can only be full while ready is low, so apply and accept
      // never compete for the pending register on the same edge.
      if (apply) begin
        cur_div   <= pend_div;
        pend_full <= 1'b0;
        div_ready <= 1'b1;
      end else if (accept) begin
        pend_div  <= div_value;
        pend_full <= 1'b1;
        div_ready <= 1'b0;
      end
    end
  end

  assign busy = (state != IDLE);

`ifdef CLKDIV_PERIOD_CNT_EN
  // Count periods started (one per rise_tick), saturating; clear on idle entry.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      period_cnt <= '0;
    end else if ((state != IDLE) && (state_next == IDLE)) begin
      period_cnt <= '0;
    end else if (step && (cnt == '0) && (period_cnt != 16'hFFFF)) begin
      period_cnt <= period_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_clock_divide_n.sv
// tb_clock_divide_n: self-checking bench for clock_divide_n with a
// cycle-level reference model described in terms of periods and positions.
module tb_clock_divide_n;

  localparam int DIV_W       = 8;
  localparam int DEFAULT_DIV = 2;

  logic             clk_in = 1'b0;
  logic             reset = 1'b1;
  logic             enable = 1'b0;
  logic             div_valid = 1'b0;
  logic [DIV_W-1:0] div_value = '0;
  logic             div_ready;
  logic             div_err;
  logic             clk_out;
  logic             rise_tick;
  logic             fall_tick;
  logic             busy;
`ifdef CLKDIV_PERIOD_CNT_EN
  logic [15:0]      period_cnt;
`endif

  int checks = 0;
  int errors = 0;

  clock_divide_n #(.DIV_W(DIV_W), .DEFAULT_DIV(DEFAULT_DIV)) dut (
    .clk_in    (clk_in),
    .reset     (reset),
    .enable    (enable),
    .div_valid (div_valid),
    .div_value (div_value),
    .div_ready (div_ready),
    .div_err   (div_err),
    .clk_out   (clk_out),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick),
    .busy      (busy)
`ifdef CLKDIV_PERIOD_CNT_EN
    ,
    .period_cnt(period_cnt)
`endif
  );

  always #5 clk_in = ~clk_in;

  // Reference model: a period of m_n cycles, m_pos is the position of the
  // next cycle inside it. High for the first ceil(n/2) positions.
  int m_n = DEFAULT_DIV;
  int m_pos = 0;
  int m_pend_n = 0;
  bit m_pend = 0;
  bit m_active = 0;
  bit m_ready = 1;
  bit m_clk = 0;
  bit m_rise = 0;
  bit m_fall = 0;
  bit m_err = 0;
  int m_pc = 0;

  task automatic model_step(input bit rst, input bit en, input bit vld, input int val);
    bit was_active;
    bit at_end;
    bit acc;
    int hi;
    if (rst) begin
      m_n = DEFAULT_DIV; m_pos = 0; m_pend = 0; m_active = 0; m_ready = 1;
      m_clk = 0; m_rise = 0; m_fall = 0; m_err = 0; m_pc = 0;
      return;
    end
    was_active = m_active;
    at_end = 0;
    m_err = vld && m_ready && (val < 2);
    acc   = vld && m_ready && (val >= 2);
    if (!was_active && !en) begin
      m_clk = 0; m_rise = 0; m_fall = 0; m_pos = 0;
    end else begin
      hi     = (m_n + 1) / 2;
      m_clk  = (m_pos < hi);
      m_rise = (m_pos == 0);
      m_fall = (m_pos == hi);
      at_end = (m_pos == m_n - 1);
      m_pos  = at_end ? 0 : m_pos + 1;
      // Keep going unless a period just completed with enable low.
      m_active = !(at_end && !en);
    end
    if (was_active && !m_active) m_pc = 0;
    else if (m_rise && m_pc < 65535) m_pc++;
    if (m_pend && (!was_active || at_end)) begin
      m_n = m_pend_n; m_pend = 0; m_ready = 1;
    end
    if (acc) begin
      m_pend = 1; m_pend_n = val; m_ready = 0;
    end
  endtask

  // One clk_in cycle: drive inputs at the falling edge, advance the model,
  // and return just after the rising edge so outputs can be sampled.
  task automatic cycle(input bit rst, input bit en, input bit vld, input int val);
    @(negedge clk_in);
    reset = rst; enable = en; div_valid = vld; div_value = DIV_W'(val);
    model_step(rst, en, vld, val);
    @(posedge clk_in);
    #1;
  endtask

  function automatic logic [5:0] obs_vec();
    return {clk_out, rise_tick, fall_tick, div_ready, div_err, busy};
  endfunction

  function automatic logic [5:0] exp_vec();
    return {m_clk, m_rise, m_fall, m_ready, m_err, m_active};
  endfunction

  task automatic test_reset();
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    checks++;
    if (obs_vec() !== 6'b000100) begin
      errors++;
      $display("FAIL reset_values: got %b expected %b", obs_vec(), 6'b000100);
    end
    checks++;
    if (obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL reset_model: got %b expected %b", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_default_run();
    for (int i = 0; i < 8; i++) begin
      cycle(0, 1, 0, 0);
      checks++;
      if ({clk_out, rise_tick, busy} !== {(i % 2) == 0, (i % 2) == 0, 1'b1}) begin
        errors++;
        $display("FAIL default_run cycle %0d: got clk/rise/busy %b%b%b expected %b%b1",
                 i, clk_out, rise_tick, busy, (i % 2) == 0, (i % 2) == 0);
      end
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL default_run_model cycle %0d: got %b expected %b", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_div_change();
    logic [9:0] win;
    bit found;
    cycle(0, 1, 1, 5);
    checks++;
    if (div_ready !== 1'b0) begin
      errors++;
      $display("FAIL div_change_ready_drop: got %b expected 0", div_ready);
    end
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle(0, 1, 0, 0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL div_change_model cycle %0d: got %b expected %b", i, obs_vec(), exp_vec());
      end
      if (div_ready === 1'b1) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL div_change_apply_timeout: div_ready stayed %b, expected 1", div_ready);
    end
    found = (rise_tick === 1'b1);
    for (int i = 0; i < 20 && !found; i++) begin
      cycle(0, 1, 0, 0);
      if (rise_tick === 1'b1) found = 1;
    end
    win = '0;
    for (int i = 0; i < 10; i++) begin
      win[9 - i] = clk_out;
      if (i < 9) cycle(0, 1, 0, 0);
    end
    checks++;
    if (!found || win !== 10'b1110011100) begin
      errors++;
      $display("FAIL div_change_pattern: got %b (rise seen %0d) expected 1110011100", win, found);
    end
  endtask

  task automatic test_div_err();
    int vals[2] = '{1, 0};
    foreach (vals[k]) begin
      cycle(0, 1, 1, vals[k]);
      checks++;
      if ({div_err, div_ready} !== 2'b11) begin
        errors++;
        $display("FAIL div_err_pulse value %0d: got err/ready %b%b expected 11", vals[k], div_err, div_ready);
      end
      cycle(0, 1, 0, 0);
      checks++;
      if (div_err !== 1'b0) begin
        errors++;
        $display("FAIL div_err_single value %0d: got %b expected 0", vals[k], div_err);
      end
    end
    for (int i = 0; i < 10; i++) begin
      cycle(0, 1, 0, 0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL div_err_model cycle %0d: got %b expected %b", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_drain();
    bit idle_seen;
    logic [2:0] exp_clk  = 3'b100;
    logic [2:0] exp_busy = 3'b110;
    idle_seen = 0;
    for (int i = 0; i < 20 && !idle_seen; i++) begin
      cycle(0, 0, 0, 0);
      if (busy === 1'b0) idle_seen = 1;
    end
    checks++;
    if (!idle_seen) begin
      errors++;
      $display("FAIL drain_idle_timeout: busy %b expected 0", busy);
    end
    cycle(0, 0, 1, 4);
    cycle(0, 0, 0, 0);
    cycle(0, 1, 0, 0);
    checks++;
    if ({clk_out, rise_tick, busy} !== 3'b111) begin
      errors++;
      $display("FAIL drain_start: got clk/rise/busy %b%b%b expected 111", clk_out, rise_tick, busy);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 0);
      checks++;
      if ({clk_out, busy} !== {exp_clk[2 - i], exp_busy[2 - i]}) begin
        errors++;
        $display("FAIL drain_seq step %0d: got clk/busy %b%b expected %b%b",
                 i, clk_out, busy, exp_clk[2 - i], exp_busy[2 - i]);
      end
    end
    for (int i = 0; i < 6; i++) begin
      cycle(0, 0, 0, 0);
      checks++;
      if ({clk_out, rise_tick, busy} !== 3'b000) begin
        errors++;
        $display("FAIL drain_quiet cycle %0d: got clk/rise/busy %b%b%b expected 000",
                 i, clk_out, rise_tick, busy);
      end
    end
  endtask

  task automatic test_reset_midop();
    logic [3:0] win;
    cycle(0, 0, 1, 5);
    cycle(0, 0, 0, 0);
    cycle(0, 1, 0, 0);
    cycle(0, 1, 1, 7);
    checks++;
    if (div_ready !== 1'b0) begin
      errors++;
      $display("FAIL midop_pending: got ready %b expected 0", div_ready);
    end
    cycle(0, 1, 0, 0);
    cycle(1, 1, 0, 0);
    checks++;
    if (obs_vec() !== 6'b000100) begin
      errors++;
      $display("FAIL midop_reset: got %b expected 000100", obs_vec());
    end
    win = '0;
    for (int i = 0; i < 4; i++) begin
      cycle(0, 1, 0, 0);
      win[3 - i] = clk_out;
    end
    checks++;
    if (win !== 4'b1010) begin
      errors++;
      $display("FAIL midop_default_div: got %b expected 1010", win);
    end
  endtask

`ifdef CLKDIV_PERIOD_CNT_EN
  task automatic test_period_cnt();
    bit idle_seen;
    cycle(1, 0, 0, 0);
    cycle(0, 0, 1, 3);
    cycle(0, 0, 0, 0);
    for (int i = 0; i < 30; i++) cycle(0, 1, 0, 0);
    checks++;
    if (period_cnt !== 16'd10) begin
      errors++;
      $display("FAIL period_cnt_ten: got %0d expected 10", period_cnt);
    end
    idle_seen = 0;
    for (int i = 0; i < 10 && !idle_seen; i++) begin
      cycle(0, 0, 0, 0);
      if (busy === 1'b0) idle_seen = 1;
    end
    checks++;
    if (!idle_seen || period_cnt !== 16'd0) begin
      errors++;
      $display("FAIL period_cnt_clear: got %0d (idle %0d) expected 0", period_cnt, idle_seen);
    end
  endtask
`endif

  task automatic test_random();
    bit en = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) en = !en;
      cycle($urandom_range(0, 299) == 0, en, $urandom_range(0, 3) == 0,
            int'($urandom_range(0, 9)));
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random cycle %0d: got %b expected %b", i, obs_vec(), exp_vec());
      end
`ifdef CLKDIV_PERIOD_CNT_EN
      checks++;
      if (period_cnt !== 16'(m_pc)) begin
        errors++;
        $display("FAIL random_period_cnt cycle %0d: got %0d expected %0d", i, period_cnt, m_pc);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_default_run();
    test_div_change();
    test_div_err();
    test_drain();
    test_reset_midop();
`ifdef CLKDIV_PERIOD_CNT_EN
    test_period_cnt();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
